// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: widths, PC-1 table, shift schedules, FSM states.
// Latency: n/a (declarations and pure helper functions only).
// Backpressure: n/a.
// Bit numbering is DES MSB-first: index 0 is the leftmost bit of every vector.
package des_pkg;

  localparam int KEY_W      = 64;
  localparam int CD_W       = 56;
  localparam int HALF_W     = 28;
  localparam int RK_W       = 48;
  localparam int NUM_ROUNDS = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_t;

  typedef logic [0:HALF_W-1] half_t;

  // PC-1 source positions, 1-based into the 64-bit key as in the DES tables.
  localparam int PC1_TBL [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // Left-shift amount applied before round i+1 in encryption order.
  localparam int ENC_SHIFT [NUM_ROUNDS] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Right-shift amount applied before decryption step n (entry 0 unused: the
  // 16 encryption shifts total 28, so PC-1 output already equals C16/D16).
  localparam int DEC_SHIFT [NUM_ROUNDS] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Rotate a 28-bit half right by 1 (two=0) or 2 (two=1).
  function automatic half_t rotr(input half_t h, input logic two);
    return two ? {h[HALF_W-2:HALF_W-1], h[0:HALF_W-3]}
               : {h[HALF_W-1], h[0:HALF_W-2]};
  endfunction

  // Rotate a 28-bit half left by 1 (two=0) or 2 (two=1).
  function automatic half_t rotl(input half_t h, input logic two);
    return two ? {h[2:HALF_W-1], h[0:1]}
               : {h[1:HALF_W-1], h[0]};
  endfunction

endpackage

// File: rtl/des_pc1.sv
// DES Permuted Choice 1: 64-bit key to 56-bit C/D register image.
// Latency: combinational.
// Backpressure: none (pure wiring).
// Ports: key [0:63] DES key (parity bits 7,15,..,63 dropped); cd [0:55] C=[0:27], D=[28:55].
module des_pc1
  import des_pkg::*;
(
  input  logic [0:KEY_W-1] key,
  output logic [0:CD_W-1]  cd
);

  for (genvar i = 0; i < CD_W; i++) begin : g_pc1
    assign cd[i] = key[PC1_TBL[i]-1];
  end

  // Parity bits do not take part in the schedule.
  logic [7:0] unused_parity;
  for (genvar p = 0; p < 8; p++) begin : g_par
    assign unused_parity[p] = key[8*p+7];
  end

endmodule

// File: rtl/des_pc2.sv
// DES Permuted Choice 2: 56-bit C/D image to 48-bit round key.
// Latency: combinational.
// Backpressure: none (pure wiring).
// Ports: cd [0:55] C/D register; rk [0:47] round key.
module des_pc2
  import des_pkg::*;
(
  input  logic [0:CD_W-1] cd,
  output logic [0:RK_W-1] rk
);

  // Source positions, 1-based into the 56-bit C/D image.
  localparam int PC2_TBL [RK_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  for (genvar i = 0; i < RK_W; i++) begin : g_pc2
    assign rk[i] = cd[PC2_TBL[i]-1];
  end

  // Eight C/D positions are never selected by PC-2.
  logic [7:0] unused_cd;
  assign unused_cd = {cd[8], cd[17], cd[21], cd[24], cd[34], cd[37], cd[42], cd[53]};

endmodule

// File: rtl/des_key_sched_dec.sv
// Sequential DES round-key generator, decryption order (K16 first, K1 last).
// Latency: key accepted at edge t -> K16 valid after edge t; one key per accepted k_ready_i.
// Backpressure: CD/step/outputs hold while k_valid_o & !k_ready_i; no new key until the sequence ends.
// Ports: clk, rst_n (async active-low); key_valid_i/key_i/key_ready_o key handshake;
//        k_valid_o/k_o/k_round_o/k_last_o/k_ready_i round-key stream;
//        enc_i (only with DES_KEY_SCHED_ENC_EN) selects encryption order when 1.
module des_key_sched_dec
  import des_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid_i,
  input  logic [0:KEY_W-1] key_i,
  output logic             key_ready_o,
  output logic             k_valid_o,
  output logic [0:RK_W-1]  k_o,
  output logic [3:0]       k_round_o,
  output logic             k_last_o,
  input  logic             k_ready_i
`ifdef DES_KEY_SCHED_ENC_EN
  ,
  input  logic             enc_i
`endif
);

  sched_state_t    state;
  logic [0:CD_W-1] cd_q;
  logic [0:CD_W-1] pc1_cd;
  logic [0:CD_W-1] cd_load;
  logic [0:CD_W-1] cd_nxt;
  logic [3:0]      step_q;
  logic [3:0]      step_inc;
  half_t           c_q;
  half_t           d_q;
  logic            sh2;

  des_pc1 u_pc1 (
    .key (key_i),
    .cd  (pc1_cd)
  );

  des_pc2 u_pc2 (
    .cd  (cd_q),
    .rk  (k_o)
  );

  assign c_q      = cd_q[0:HALF_W-1];
  assign d_q      = cd_q[HALF_W:CD_W-1];
  // Wraps to 0 at step 15, where no rotation is performed.
  assign step_inc = step_q + 4'd1;

`ifdef DES_KEY_SCHED_ENC_EN
  logic enc_q;

  always_comb begin
    sh2       = 1'b0;
    cd_load   = pc1_cd;
    cd_nxt    = cd_q;
    k_round_o = 4'd15 - step_q;
    if (enc_q) begin
      sh2       = (ENC_SHIFT[step_inc] == 2);
      cd_nxt    = {rotl(c_q, sh2), rotl(d_q, sh2)};
      k_round_o = step_q;
    end else begin
      sh2    = (DEC_SHIFT[step_inc] == 2);
      cd_nxt = {rotr(c_q, sh2), rotr(d_q, sh2)};
    end
    // Encryption starts from C1/D1, one left rotation past PC-1.
    if (enc_i) begin
      cd_load = {rotl(pc1_cd[0:HALF_W-1], 1'b0), rotl(pc1_cd[HALF_W:CD_W-1], 1'b0)};
    end
  end
`else
  always_comb begin
    sh2       = (DEC_SHIFT[step_inc] == 2);
    cd_load   = pc1_cd;
    cd_nxt    = {rotr(c_q, sh2), rotr(d_q, sh2)};
    k_round_o = 4'd15 - step_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cd_q   <= '0;
      step_q <= 4'd0;
`ifdef DES_KEY_SCHED_ENC_EN
      enc_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (key_valid_i) begin
            cd_q   <= cd_load;
            step_q <= 4'd0;
`ifdef DES_KEY_SCHED_ENC_EN
            enc_q  <= enc_i;
`endif
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (k_ready_i) begin
            if (step_q == 4'd15) begin
              // Step cleared so IDLE outputs match the reset view.
              step_q <= 4'd0;
              state  <= ST_IDLE;
            end else begin
              cd_q   <= cd_nxt;
              step_q <= step_inc;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign key_ready_o = (state == ST_IDLE);
  assign k_valid_o   = (state == ST_RUN);
  assign k_last_o    = (step_q == 4'd15);

endmodule

// File: tb/tb_des_key_sched_dec.sv
// Directed bench for des_key_sched_dec: reset, decryption order, backpressure,
// key ignored while running, mid-sequence reset, all-zero keys.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_des_key_sched_dec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        key_valid_i = 1'b0;
  logic [0:63] key_i = '0;
  logic        key_ready_o;
  logic        k_valid_o;
  logic [0:47] k_o;
  logic [3:0]  k_round_o;
  logic        k_last_o;
  logic        k_ready_i = 1'b0;
`ifdef DES_KEY_SCHED_ENC_EN
  logic        enc_i = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

  // Round keys K1..K16 for KEY_A (index = round - 1).
  localparam logic [47:0] EXP_K [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  des_key_sched_dec dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid_i (key_valid_i),
    .key_i       (key_i),
    .key_ready_o (key_ready_o),
    .k_valid_o   (k_valid_o),
    .k_o         (k_o),
    .k_round_o   (k_round_o),
    .k_last_o    (k_last_o),
    .k_ready_i   (k_ready_i)
`ifdef DES_KEY_SCHED_ENC_EN
    ,
    .enc_i       (enc_i)
`endif
  );

  always #5 clk = ~clk;

  // Offer a key (called at a falling edge) and return at the falling edge
  // after it was taken, so K-first is on the outputs.
  task automatic load_key(input logic [63:0] k);
    int t;
    t = 0;
    key_i = k;
    key_valid_i = 1'b1;
    while (key_ready_o !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (key_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL load_key_timeout: key_ready_o=%b after %0d cycles, want 1", key_ready_o, t);
    end
    @(negedge clk);
    key_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (key_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_key_ready: got %b want 1", key_ready_o); end
    vectors++;
    if (k_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_k_valid: got %b want 0", k_valid_o); end
    vectors++;
    if (k_o !== 48'h0) begin miscompares++; $display("FAIL reset_k: got %h want 000000000000", k_o); end
    vectors++;
    if (k_round_o !== 4'd15) begin miscompares++; $display("FAIL reset_round: got %0d want 15", k_round_o); end
    vectors++;
    if (k_last_o !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b want 0", k_last_o); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_dec_order();
    k_ready_i = 1'b1;
    load_key(KEY_A);
    for (int n = 0; n < 16; n++) begin
      vectors++;
      if (k_valid_o !== 1'b1 || k_o !== EXP_K[15-n] || k_round_o !== 4'(15 - n) || k_last_o !== (n == 15)) begin
        miscompares++;
        $display("FAIL dec_order step %0d: valid=%b k=%h round=%0d last=%b, want valid=1 k=%h round=%0d last=%b",
                 n, k_valid_o, k_o, k_round_o, k_last_o, EXP_K[15-n], 15 - n, (n == 15));
      end
      @(negedge clk);
    end
    vectors++;
    if (key_ready_o !== 1'b1 || k_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL dec_order_idle: key_ready=%b valid=%b, want 1 0", key_ready_o, k_valid_o);
    end
  endtask

  task automatic test_backpressure();
    int idx;
    int cyc;
    k_ready_i = 1'b0;
    load_key(KEY_A);
    idx = 15;
    cyc = 0;
    while (idx >= 0 && cyc < 300) begin
      vectors++;
      if (k_valid_o !== 1'b1 || k_o !== EXP_K[idx] || k_round_o !== 4'(idx) || k_last_o !== (idx == 0)) begin
        miscompares++;
        $display("FAIL backpressure cyc %0d: valid=%b k=%h round=%0d last=%b, want valid=1 k=%h round=%0d last=%b",
                 cyc, k_valid_o, k_o, k_round_o, k_last_o, EXP_K[idx], idx, (idx == 0));
      end
      k_ready_i = (cyc % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      if (k_ready_i) idx--;
      cyc++;
      @(negedge clk);
    end
    vectors++;
    if (idx >= 0) begin
      miscompares++;
      $display("FAIL backpressure_timeout: %0d keys left, want 0", idx + 1);
    end
    k_ready_i = 1'b1;
    vectors++;
    if (key_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure_idle: key_ready=%b want 1", key_ready_o);
    end
  endtask

  task automatic test_ignore_key();
    k_ready_i = 1'b1;
    load_key(KEY_A);
    for (int n = 0; n < 16; n++) begin
      if (n == 3) begin
        key_i = 64'hFEDCBA9876543210;
        key_valid_i = 1'b1;
      end
      if (n == 6) key_valid_i = 1'b0;
      vectors++;
      if (key_ready_o !== 1'b0 || k_o !== EXP_K[15-n] || k_round_o !== 4'(15 - n)) begin
        miscompares++;
        $display("FAIL ignore_key step %0d: key_ready=%b k=%h round=%0d, want 0 %h %0d",
                 n, key_ready_o, k_o, k_round_o, EXP_K[15-n], 15 - n);
      end
      @(negedge clk);
    end
    vectors++;
    if (key_ready_o !== 1'b1 || k_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_key_idle: key_ready=%b valid=%b, want 1 0", key_ready_o, k_valid_o);
    end
  endtask

  task automatic test_mid_reset();
    k_ready_i = 1'b1;
    load_key(KEY_A);
    repeat (5) @(negedge clk);
    vectors++;
    if (k_o !== EXP_K[10] || k_round_o !== 4'd10) begin
      miscompares++;
      $display("FAIL mid_reset_pre: k=%h round=%0d, want %h 10", k_o, k_round_o, EXP_K[10]);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (key_ready_o !== 1'b1 || k_valid_o !== 1'b0 || k_o !== 48'h0 || k_round_o !== 4'd15 || k_last_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: ready=%b valid=%b k=%h round=%0d last=%b, want 1 0 000000000000 15 0",
               key_ready_o, k_valid_o, k_o, k_round_o, k_last_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (k_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_no_resume: valid=%b want 0", k_valid_o);
    end
    load_key(KEY_A);
    vectors++;
    if (k_valid_o !== 1'b1 || k_o !== EXP_K[15] || k_round_o !== 4'd15) begin
      miscompares++;
      $display("FAIL mid_reset_restart: valid=%b k=%h round=%0d, want 1 %h 15", k_valid_o, k_o, k_round_o, EXP_K[15]);
    end
    repeat (16) @(negedge clk);
  endtask

  task automatic test_zero_keys();
    logic [63:0] keys [2];
    keys[0] = 64'h0101010101010101;
    keys[1] = 64'h0000000000000000;
    k_ready_i = 1'b1;
    for (int j = 0; j < 2; j++) begin
      load_key(keys[j]);
      for (int n = 0; n < 16; n++) begin
        vectors++;
        if (k_valid_o !== 1'b1 || k_o !== 48'h0) begin
          miscompares++;
          $display("FAIL zero_key %0d step %0d: valid=%b k=%h, want 1 000000000000", j, n, k_valid_o, k_o);
        end
        @(negedge clk);
      end
      vectors++;
      if (key_ready_o !== 1'b1) begin
        miscompares++;
        $display("FAIL zero_key_idle %0d: key_ready=%b want 1", j, key_ready_o);
      end
    end
  endtask

`ifdef DES_KEY_SCHED_ENC_EN
  task automatic test_enc_order();
    k_ready_i = 1'b1;
    enc_i = 1'b1;
    load_key(KEY_A);
    enc_i = 1'b0;
    for (int n = 0; n < 16; n++) begin
      vectors++;
      if (k_valid_o !== 1'b1 || k_o !== EXP_K[n] || k_round_o !== 4'(n) || k_last_o !== (n == 15)) begin
        miscompares++;
        $display("FAIL enc_order step %0d: valid=%b k=%h round=%0d last=%b, want 1 %h %0d %b",
                 n, k_valid_o, k_o, k_round_o, k_last_o, EXP_K[n], n, (n == 15));
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_dec_order();
    test_backpressure();
    test_ignore_key();
    test_mid_reset();
    test_zero_keys();
`ifdef DES_KEY_SCHED_ENC_EN
    test_enc_order();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
